// File: rtl/serial_or_pkg.sv
// Shared types and parameter sanity helpers for the serial OR-reduction stage.
package serial_or_pkg;

  // Frame sequencing states: gathering bits, or holding a finished result.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Legal frame length is 1..255 and out_len must be able to hold FRAME_LEN.
  function automatic bit params_ok(int unsigned frame_len, int unsigned len_w);
    return (frame_len >= 32'd1) && (frame_len <= 32'd255) &&
           (len_w >= 32'd1) && (len_w < 32'd32) &&
           ((64'd1 << len_w) > 64'(frame_len));
  endfunction

endpackage

// File: rtl/or_gate_using_mux.sv
// Two-input OR built from a 2:1 mux: when a is set the result is forced high, otherwise b passes.
module or_gate_using_mux (
  input  logic a,
  input  logic b,
  output logic y
);

  // Mux select is a; the 1-leg is tied high.
  assign y = a ? 1'b1 : b;

endmodule

// File: rtl/serial_or_reduce.sv
// Serial OR-reduction: ORs accepted bits of a frame (FRAME_LEN bits or closed
// early by in_last) and holds one registered result until downstream takes it.
module serial_or_reduce
  import serial_or_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_or,
  output logic [LEN_W-1:0] out_len,
  output logic             out_early
);

  // Reject illegal parameter combinations at elaboration.
  if (!params_ok(FRAME_LEN, LEN_W)) begin : g_param_check
    $error("serial_or_reduce: FRAME_LEN must be 1..255 and 2**LEN_W > FRAME_LEN");
  end

  localparam logic [LEN_W-1:0] LAST_IDX  = LEN_W'(FRAME_LEN - 1);
  localparam logic [LEN_W-1:0] FRAME_MAX = LEN_W'(FRAME_LEN);

  state_e             state_q, state_d;
  logic               acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_d;
  logic               out_or_d;
  logic [LEN_W-1:0]   out_len_d;
  logic               out_early_d;

  logic               or_y;
  logic               accept;
  logic               final_bit;
  logic [LEN_W-1:0]   cnt_inc;

  // Ready only while gathering, and never during reset.
  assign in_ready  = !rst && (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + LEN_W'(1);
  // Frame closes on in_last or on the FRAME_LEN-th bit; only meaningful when accept is high.
  assign final_bit = in_last || (cnt_q == LAST_IDX);

  // Per-bit combine; feeds both the running accumulator and the result capture.
  or_gate_using_mux u_or (
    .a (acc_q),
    .b (in_bit),
    .y (or_y)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_or_d    = out_or;
    out_len_d   = out_len;
    out_early_d = out_early;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (final_bit) begin
            out_or_d    = or_y;
            out_len_d   = cnt_inc;
            out_early_d = in_last && (cnt_inc < FRAME_MAX);
            acc_d       = 1'b0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d = or_y;
            cnt_d = cnt_inc;
          end
        end
      end
      HOLD: begin
        // Data outputs keep their value after the handshake.
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    out_valid_d = (state_d == HOLD);
  end

  // State and output registers; reset discards any partial frame or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_or    <= 1'b0;
      out_len   <= '0;
      out_early <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_valid <= out_valid_d;
      out_or    <= out_or_d;
      out_len   <= out_len_d;
      out_early <= out_early_d;
    end
  end

endmodule

// File: tb/tb_serial_or_reduce.sv
// Bench for serial_or_reduce: FRAME_LEN=8 instance (index 0) and FRAME_LEN=1 instance (index 1).
module tb_serial_or_reduce;

  typedef struct packed {
    logic       o;
    logic [7:0] len;
    logic       early;
  } res_t;

  typedef struct {
    logic [7:0] bits;
    int         n;
    bit         last;
    bit         gap;
    bit         e_or;
    int         e_len;
    bit         e_early;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] iv, ib, il, ordy;
  logic       ir0, ir1, ov0, ov1, oor0, oor1, oe0, oe1;
  logic [7:0] olen0, olen1;
  logic [1:0] ir, ov, oor, oe;

  assign ir  = {ir1, ir0};
  assign ov  = {ov1, ov0};
  assign oor = {oor1, oor0};
  assign oe  = {oe1, oe0};

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  res_t q0[$];
  res_t q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_or_reduce #(.FRAME_LEN(8), .LEN_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir0), .in_bit(ib[0]), .in_last(il[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .out_or(oor0), .out_len(olen0), .out_early(oe0)
  );

  serial_or_reduce #(.FRAME_LEN(1), .LEN_W(8)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir1), .in_bit(ib[1]), .in_last(il[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .out_or(oor1), .out_len(olen1), .out_early(oe1)
  );

  task automatic chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_exp(int s, bit o, int len, bit early);
    res_t r;
    r.o = o;
    r.len = 8'(len);
    r.early = early;
    if (s == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic pop_check(int s, res_t got);
    res_t e;
    int   sz;
    sz = (s == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      total_cnt++;
      $display("FAIL unexpected_result dut%0d: got or=%0d len=%0d early=%0d expected no result",
               s, got.o, got.len, got.early);
    end else begin
      e = (s == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("out_or dut%0d", s), int'(got.o), int'(e.o));
      chk($sformatf("out_len dut%0d", s), int'(got.len), int'(e.len));
      chk($sformatf("out_early dut%0d", s), int'(got.early), int'(e.early));
    end
  endtask

  // Scoreboard: a result is consumed on a cycle with out_valid && out_ready.
  always @(negedge clk) begin
    if (ov[0] && ordy[0]) pop_check(0, {oor0, olen0, oe0});
    if (ov[1] && ordy[1]) pop_check(1, {oor1, olen1, oe1});
  end

  // Offer one bit and wait for it to be accepted; returns at posedge+1 of the accepting edge.
  task automatic send_bit(int s, bit b, bit l, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    iv[s] = 1'b1;
    ib[s] = b;
    il[s] = l;
    for (int t = 0; t < 50; t++) begin
      ok = ir[s];
      @(posedge clk);
      #1;
      if (ok) break;
    end
    acc_cyc = cyc;
    iv[s] = 1'b0;
    ib[s] = 1'bx;
    il[s] = 1'bx;
    if (!ok) begin
      total_cnt++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0 for 50 cycles expected 1", s);
    end
  endtask

  task automatic send_frame(int s, frame_t f);
    int c;
    push_exp(s, f.e_or, f.e_len, f.e_early);
    for (int i = 0; i < f.n; i++) begin
      send_bit(s, f.bits[i], f.last && (i == f.n - 1), c);
      if (f.gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    frame_t vecs[8];
    frame_t z8;
    int     c0, c1, c2, c;

    // bits[i] is the i-th bit sent
    vecs[0] = '{bits: 8'h08, n: 8, last: 1'b0, gap: 1'b0, e_or: 1'b1, e_len: 8, e_early: 1'b0};
    vecs[1] = '{bits: 8'h00, n: 8, last: 1'b0, gap: 1'b1, e_or: 1'b0, e_len: 8, e_early: 1'b0};
    vecs[2] = '{bits: 8'h01, n: 1, last: 1'b1, gap: 1'b0, e_or: 1'b1, e_len: 1, e_early: 1'b1};
    vecs[3] = '{bits: 8'h04, n: 3, last: 1'b1, gap: 1'b0, e_or: 1'b1, e_len: 3, e_early: 1'b1};
    vecs[4] = '{bits: 8'h80, n: 8, last: 1'b1, gap: 1'b0, e_or: 1'b1, e_len: 8, e_early: 1'b0};
    vecs[5] = '{bits: 8'h00, n: 5, last: 1'b1, gap: 1'b0, e_or: 1'b0, e_len: 5, e_early: 1'b1};
    vecs[6] = '{bits: 8'hFF, n: 8, last: 1'b0, gap: 1'b0, e_or: 1'b1, e_len: 8, e_early: 1'b0};
    vecs[7] = '{bits: 8'h01, n: 7, last: 1'b1, gap: 1'b1, e_or: 1'b1, e_len: 7, e_early: 1'b1};
    z8      = '{bits: 8'h00, n: 8, last: 1'b0, gap: 1'b0, e_or: 1'b0, e_len: 8, e_early: 1'b0};

    iv   = 2'b00;
    ib   = 2'bxx;
    il   = 2'bxx;
    ordy = 2'b00;
    rst  = 1'b1;
    idle(2);

    // Outputs while in reset
    chk("rst in_ready", int'(ir[0]), 0);
    chk("rst out_valid", int'(ov[0]), 0);
    chk("rst out_or", int'(oor[0]), 0);
    chk("rst out_len", int'(olen0), 0);
    chk("rst out_early", int'(oe[0]), 0);

    rst = 1'b0;
    idle(1);
    chk("in_ready after rst", int'(ir[0]), 1);
    idle(3);
    chk("idle out_valid", int'(ov[0]), 0);

    // Table of frames with downstream always ready
    ordy = 2'b11;
    for (int k = 0; k < 8; k++) send_frame(0, vecs[k]);
    idle(3);

    // Backpressure: result must hold for 5 cycles with in_ready low
    ordy[0] = 1'b0;
    push_exp(0, 1'b1, 3, 1'b1);
    send_bit(0, 1'b0, 1'b0, c);
    send_bit(0, 1'b0, 1'b0, c);
    send_bit(0, 1'b1, 1'b1, c);
    chk("latency out_valid", int'(ov[0]), 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d out_valid", k), int'(ov[0]), 1);
      chk($sformatf("hold%0d out_or", k), int'(oor[0]), 1);
      chk($sformatf("hold%0d out_len", k), int'(olen0), 3);
      chk($sformatf("hold%0d out_early", k), int'(oe[0]), 1);
      chk($sformatf("hold%0d in_ready", k), int'(ir[0]), 0);
      idle(1);
    end
    ordy[0] = 1'b1;
    idle(1);
    chk("release in_ready", int'(ir[0]), 1);
    chk("release out_valid", int'(ov[0]), 0);
    chk("release out_or kept", int'(oor[0]), 1);
    chk("release out_len kept", int'(olen0), 3);
    chk("release out_early kept", int'(oe[0]), 1);

    // Reset mid-frame discards four ones
    for (int k = 0; k < 4; k++) send_bit(0, 1'b1, 1'b0, c);
    rst = 1'b1;
    idle(1);
    chk("midrst out_valid", int'(ov[0]), 0);
    chk("midrst in_ready", int'(ir[0]), 0);
    rst = 1'b0;
    idle(1);
    send_frame(0, z8);
    idle(3);

    // FRAME_LEN=1: every bit is a frame, one bubble between accepts
    push_exp(1, 1'b1, 1, 1'b0);
    push_exp(1, 1'b0, 1, 1'b0);
    push_exp(1, 1'b1, 1, 1'b0);
    send_bit(1, 1'b1, 1'b0, c0);
    send_bit(1, 1'b0, 1'b0, c1);
    send_bit(1, 1'b1, 1'b0, c2);
    chk("fl1 accept spacing 1", c1 - c0, 2);
    chk("fl1 accept spacing 2", c2 - c1, 2);
    idle(4);

    chk("dut8 results outstanding", q0.size(), 0);
    chk("dut1 results outstanding", q1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_or_reduce.md
Name: serial_or_reduce

Overview:
- Sequential OR-reduction stage that consumes a serial bit stream over a valid/ready handshake.
- Accumulates the OR of every accepted bit across a frame of FRAME_LEN bits, or fewer if in_last arrives early, then presents a single registered result downstream.
- Each per-bit combine is done by one instance of the team's mux-built OR cell; this block adds the sequencing around that cell.

Parameters:
- FRAME_LEN, 8, maximum bits per frame; legal range 1..255.
- LEN_W, 8, width of the out_len field; must satisfy 2**LEN_W > FRAME_LEN.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, upstream has a bit.
- in_ready, output, 1, block can accept a bit this cycle.
- in_bit, input, 1, serial data bit.
- in_last, input, 1, marks the accepted bit as the final bit of the frame.
- out_valid, output, 1, a frame result is held.
- out_ready, input, 1, downstream takes the result.
- out_or, output, 1, OR of all bits in the frame.
- out_len, output, LEN_W, number of bits in the frame (1..FRAME_LEN).
- out_early, output, 1, frame was closed by in_last before reaching FRAME_LEN bits.

Behaviour:
- Asynchronous reset, while rst is high:
  - state=ACCUM; acc=0; cnt=0.
  - out_valid=0, out_or=0, out_len=0, out_early=0.
  - in_ready=0 (gated by rst).
- States: ACCUM and HOLD.
  - in_ready = !rst && (state==ACCUM).
  - out_valid is a register: 1 exactly when state==HOLD.
- Accept: a bit is accepted when in_valid && in_ready.
  - in_bit and in_last are ignored in every other cycle, including X values.
- ACCUM, accepted bit that is not final:
  - acc <= acc | in_bit.
  - cnt <= cnt+1.
- Final bit: an accepted bit with in_last=1, or an accepted bit with cnt==FRAME_LEN-1.
  - out_or <= acc | in_bit.
  - out_len <= cnt+1.
  - out_early <= in_last && (cnt+1 < FRAME_LEN).
  - acc <= 0; cnt <= 0; state <= HOLD.
- in_last on the FRAME_LEN-th bit gives out_early=0.
- Latency: out_valid rises in the cycle after the final bit is accepted.
- HOLD:
  - in_ready=0.
  - out_or, out_len and out_early are stable until the handshake.
  - When out_ready=1, state <= ACCUM and out_valid <= 0. Data outputs keep their last value.
  - in_ready returns to 1 in the next cycle. Throughput is one bubble cycle per frame.
- out_ready held high continuously: out_valid is high for exactly one cycle per frame.
- out_ready while in ACCUM: no effect.
- FRAME_LEN=1: every accepted bit is a frame; out_len=1 and out_early=0 always.
- Reset mid-frame or mid-HOLD: the partial frame or pending result is discarded. No output is produced for it.
- cnt never exceeds FRAME_LEN-1. No wrap-around is reachable.

Decomposition:
- Package serial_or_pkg:
  - state_e enum {ACCUM, HOLD}.
  - Elaboration-time check that FRAME_LEN >= 1 and 2**LEN_W > FRAME_LEN.
- Sub-module: one or_gate_using_mux instance with a=acc, b=in_bit; its output feeds both the acc update and the out_or capture.
- Target size: 120-200 lines of RTL.

Test Plan:
- Reset then idle, FRAME_LEN=8 -> all outputs 0 during rst; in_ready=1 one cycle after rst falls; out_valid stays 0.
- 8 accepted bits 0,0,0,1,0,0,0,0 with out_ready=1 -> out_valid pulses one cycle after the 8th accept; out_or=1, out_len=8, out_early=0.
- 8 zero bits with in_valid toggling every other cycle -> only valid cycles are counted; out_or=0, out_len=8.
- Bits 0,0,1 with in_last on the 3rd, out_ready=0 for 5 cycles -> out_or=1, out_len=3, out_early=1; outputs held stable and in_ready=0 for all 5 cycles; in_ready=1 the cycle after out_ready goes high.
- rst asserted after 4 accepted bits of 1 -> no output; next frame of 8 zeros gives out_or=0, out_len=8.
- FRAME_LEN=1, stream 1,0,1 with out_ready=1 -> three results: out_or = 1,0,1; out_len=1 each; one bubble between accepts.
